// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (11-bit frame); otherwise the frame is 10 bits.
module uart_tx_parity #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] dbg_state_o
);

  // Handshake: tx_start is a strobe honoured only while idle (tx_busy low, which includes
  // the tx_done cycle); tx_data is captured on that edge and ignored afterwards. A strobe
  // while tx_busy is high is dropped, never queued.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd3
`endif
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        baud_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_end    = (baud_q == BAUD_LAST);
  assign tx_serial   = serial_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          baud_d   = '0;
          state_d  = S_START;
          busy_d   = 1'b1;
          serial_d = 1'b0;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      // The shift register always holds the next data bit in position 0.
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = S_PARITY;
`else
            serial_d = 1'b1;
            state_d  = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d   = '0;
          serial_d = 1'b1;
          state_d  = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (baud_end) begin
          baud_d   = '0;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        baud_d   = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Self-checking bench for uart_tx_parity: table-driven frames, corner sequences and random bytes.
module tb_uart_tx_parity;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int N = 11;
`else
  localparam int N = 10;
`endif

  logic       clock;
  logic       reset_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {tx_serial, tx_busy, tx_done} expected per cycle.
  logic [2:0] exp_q[$];

  uart_tx_parity #(.CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         inj_at;
    logic [7:0] inj_data;
  } vec_t;

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got {serial,busy,done}=%b want=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Transmit order: index 0 = start bit, then data LSB first, parity (if built), stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (N == 11) begin
      f[9]  = p;
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  // Driver: call right after a negedge; the following posedge is the accept edge.
  task automatic start_frame(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clock);
    #1 tx_start = 1'b0;
  endtask

  // Checks cycles k+1 .. k+N*C+1 after the accept edge; optional stray strobe at inj_at.
  task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                             input int inj_at, input logic [7:0] inj_data);
    logic [10:0] fb;
    logic [2:0]  e;
    fb = frame_bits(d, p);
    for (int t = 1; t <= N * C; t++) exp_q.push_back({fb[(t - 1) / C], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
    for (int t = 1; exp_q.size() > 0; t++) begin
      @(negedge clock);
      if (inj_at > 0 && t == inj_at) begin
        tx_start = 1'b1;
        tx_data  = inj_data;
      end else begin
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
      end
      e = exp_q.pop_front();
      check3(name, {tx_serial, tx_busy, tx_done}, e);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check3(name, {tx_serial, tx_busy, tx_done}, 3'b100);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    int gap;

    vecs[0] = '{8'hA5, 1'b0, 13, 8'h3C};
    vecs[1] = '{8'h07, 1'b1, 0,  8'h00};
    vecs[2] = '{8'h00, 1'b0, 0,  8'h00};
    vecs[3] = '{8'hFF, 1'b0, 30, 8'h00};
    vecs[4] = '{8'h01, 1'b1, 0,  8'h00};
    vecs[5] = '{8'h80, 1'b1, 5,  8'hFF};

    reset_n  = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    @(negedge clock);
    check3("reset_state", {tx_serial, tx_busy, tx_done}, 3'b100);
    @(negedge clock);
    reset_n = 1'b1;
    check_idle("idle_after_reset", 3);

    // Table-driven frames, some with a stray strobe mid-frame that must be ignored.
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].data);
      check_frame($sformatf("table%0d", i), vecs[i].data, vecs[i].par,
                  vecs[i].inj_at, vecs[i].inj_data);
      check_idle($sformatf("table%0d_after", i), 2);
    end

    // Back-to-back: strobe held in the tx_done cycle is accepted on the next edge.
    @(negedge clock);
    start_frame(8'hA5);
    check_frame("b2b_first", 8'hA5, 1'b0, 0, 8'h00);
    start_frame(8'h55);
    check_frame("b2b_second", 8'h55, 1'b0, 0, 8'h00);
    check_idle("b2b_after", 2);

    // Reset during data bit 3 aborts the frame immediately.
    @(negedge clock);
    start_frame(8'hA5);
    for (int t = 1; t <= 4 * C + 2; t++) @(negedge clock);
    reset_n = 1'b0;
    #1 check3("reset_abort", {tx_serial, tx_busy, tx_done}, 3'b100);
    @(negedge clock);
    check3("reset_hold", {tx_serial, tx_busy, tx_done}, 3'b100);
    reset_n = 1'b1;
    check_idle("after_abort", N * C + 4);
    start_frame(8'h3C);
    check_frame("after_abort_frame", 8'h3C, 1'b0, 0, 8'h00);

    // Random bytes against the reference frame model, random idle gaps and stray strobes.
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      start_frame(d);
      check_frame($sformatf("rand%0d", i), d, 1'($countones(d) % 2),
                  (($urandom_range(0, 1) == 1) ? int'($urandom_range(2, N * C - 1)) : 0),
                  8'($urandom));
      gap = $urandom_range(0, 3);
      if (gap > 0) check_idle($sformatf("rand%0d_gap", i), gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
